sdram_port_arbiter: RTL and testbench
=====================================

Name: sdram_port_arbiter

Overview:
- Shares the single SDRAM controller CPU-side port between the instruction-fetch requester (32-bit fetch) and the data requester (16-bit read/write).
- Sequences one transaction at a time: grant, issue, wait for acknowledge, wait for completion, return the result to the owning requester.
- Data port has priority.
- A streak limit guarantees fetch forward progress, and a timeout recovers from a stalled controller.
- Sits between the CPU memory stage / fetch unit and the SDRAM controller, in the controller's srclk domain.

Parameters:
- MAX_DATA_STREAK, 4: consecutive data grants allowed while a fetch is pending; the next grant is then forced to fetch.
- TIMEOUT_CYC, 1023: cycles allowed in any wait state before abort; 10-bit counter.

Ports:
- clk  in  1  system clock (controller srclk domain)
- rst_n  in  1  asynchronous active-low reset
- f_addr  in  23  fetch word address
- f_req  in  1  fetch request; level, held until f_ready
- f_data  out  32  fetched instruction pair
- f_ready  out  1  one-cycle pulse; f_data valid
- d_addr  in  23  data address
- d_wdata  in  16  write data
- d_rd_req  in  1  data read request; level
- d_wr_req  in  1  data write request; level
- d_rdata  out  16  read data
- d_ready  out  1  one-cycle pulse; data read or write complete
- m_addr  out  23  to controller c_addr
- m_wdata  out  16  to controller c_data_in
- m_read_req  out  1  to controller c_read_req
- m_write_req  out  1  to controller c_write_req
- m_instr_mode  out  1  to controller instruction_mode
- m_rdata  in  32  from controller c_data_out
- m_busy  in  1  from controller c_busy
- m_read_ready  in  1  from controller c_read_ready
- m_cack  in  1  from controller c_cack
- arb_timeout  out  1  one-cycle pulse on abort

Behaviour:
- Reset (async, rst_n low): state IDLE.
  - All outputs 0.
  - Streak counter 0, timeout counter 0.
  - m_addr / m_wdata are 0.
- Grant, evaluated in IDLE only, and only when m_busy is 0:
  - d_rd_req or d_wr_req takes the grant, unless f_req is pending and streak equals MAX_DATA_STREAK; then fetch takes it.
  - If both d_rd_req and d_wr_req are high, the write is served.
  - On grant, latch into registers: address, wdata, kind (FETCH / DRD / DWR).
  - Streak update: data grant increments it (saturating at MAX_DATA_STREAK); fetch grant, or IDLE with no f_req, clears it to 0.
- Issue state ISSUE:
  - Drive the latched m_addr / m_wdata.
  - m_instr_mode = 1 for FETCH only.
  - Assert m_read_req (FETCH, DRD) or m_write_req (DWR) until the cycle m_cack=1 is sampled.
  - Deassert the request the same cycle cack is seen, then go to WAIT_RD or WAIT_WR.
- m_addr, m_wdata and m_instr_mode stay stable from ISSUE until the return to IDLE; the controller samples them late.
- WAIT_RD:
  - Completes on the rising edge of m_read_ready. The edge-detect history is cleared on entering ISSUE.
  - FETCH: f_data <= m_rdata; pulse f_ready.
  - DRD: d_rdata <= m_rdata[15:0]; pulse d_ready.
  - Then go to IDLE.
- WAIT_WR:
  - Tracks a seen_busy flag; completes on the first m_busy=0 after seen_busy=1.
  - Then pulse d_ready and go to IDLE.
- Result registers hold their value until the next completion of the same kind.
- Requesters must drop req in the cycle after their ready pulse.
  - In IDLE, the arbiter ignores a req that is still high in the same cycle as its own ready pulse; there is a 1-cycle IDLE minimum.
- Timeout:
  - Counter clears on leaving IDLE and counts in ISSUE / WAIT_*.
  - On reaching TIMEOUT_CYC: deassert m_*_req, pulse arb_timeout, and go to IDLE. No ready pulse is given; the requester retries by holding req.
- Request withdrawn mid-transaction: the transaction still completes and the ready pulse is still given.
- Reset mid-transaction: immediate return to IDLE; any controller-side completion is discarded.

Optional Feature:
- Macro ARB_RR_EN.
- Defined: strict round-robin between fetch and data. After any grant, the other class has priority when both are pending. The streak counter is removed and MAX_DATA_STREAK is unused.
- Undefined: data-priority with streak limit, as above.

Test Plan:
- Single fetch:
  - Stimulus: f_req, f_addr=0x000100; model returns m_rdata=0xDEADBEEF.
  - Response: m_instr_mode=1, m_read_req held until cack; f_data=0xDEADBEEF; exactly one f_ready; d_ready stays 0.
- Data write then read:
  - Stimulus: d_wr_req, d_addr=0x000010, d_wdata=0x1234; then d_rd_req at the same address.
  - Response: m_write_req, one d_ready after the busy high→low sequence; read gives d_rdata=0x1234.
- Starvation bound:
  - Stimulus: d_rd_req continuously high, f_req high, MAX_DATA_STREAK=4.
  - Response: exactly 4 data completions, then 1 fetch completion, repeating.
- Simultaneous d_rd_req and d_wr_req:
  - Response: write issued first, then read.
- Timeout:
  - Stimulus: controller never asserts cack, TIMEOUT_CYC=1023.
  - Response: arb_timeout pulses at cycle 1023 after ISSUE entry; m_read_req drops; arbiter re-issues on the next IDLE.
- Async reset asserted in WAIT_RD, then a late m_read_ready:
  - Response: all outputs 0 immediately; no f_ready or d_ready pulse.

Source files
------------

// File: rtl/sdram_port_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the port arbiter and the SDRAM controller CPU port.
interface sdram_port_arbiter_if;
  logic [22:0] f_addr;
  logic        f_req;
  logic [31:0] f_data;
  logic        f_ready;

  logic [22:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_rd_req;
  logic        d_wr_req;
  logic [15:0] d_rdata;
  logic        d_ready;

  logic [22:0] m_addr;
  logic [15:0] m_wdata;
  logic        m_read_req;
  logic        m_write_req;
  logic        m_instr_mode;
  logic [31:0] m_rdata;
  logic        m_busy;
  logic        m_read_ready;
  logic        m_cack;

  logic        arb_timeout;

  // arbiter side
  modport slave (
    input  f_addr, f_req, d_addr, d_wdata, d_rd_req, d_wr_req,
           m_rdata, m_busy, m_read_ready, m_cack,
    output f_data, f_ready, d_rdata, d_ready,
           m_addr, m_wdata, m_read_req, m_write_req, m_instr_mode, arb_timeout
  );

  // requester / controller environment side
  modport master (
    output f_addr, f_req, d_addr, d_wdata, d_rd_req, d_wr_req,
           m_rdata, m_busy, m_read_ready, m_cack,
    input  f_data, f_ready, d_rdata, d_ready,
           m_addr, m_wdata, m_read_req, m_write_req, m_instr_mode, arb_timeout
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Shares the SDRAM controller CPU port between instruction fetch and data access, one transaction at a time.
// Optional macro ARB_RR_EN: strict fetch/data round-robin instead of data priority with a streak limit.
//
// state   | meaning
// IDLE    | arbitrate; no grant while a ready/timeout pulse is out (1-cycle minimum)
// ISSUE   | drive latched request until controller acknowledges
// WAIT_RD | wait for rising edge of m_read_ready, capture result
// WAIT_WR | wait for busy high then low
module sdram_port_arbiter #(
  parameter int MAX_DATA_STREAK = 4,
  parameter int TIMEOUT_CYC     = 1023
) (
  input logic                 clk,
  input logic                 rst_n,
  sdram_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_RD, S_WAIT_WR} state_t;
  typedef enum logic [1:0] {K_FETCH, K_DRD, K_DWR} kind_t;

  localparam logic [9:0] TMO_LIMIT = 10'(TIMEOUT_CYC);

  state_t      state_q, state_d;
  kind_t       kind_q, kind_d;
  logic [22:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        instr_q, instr_d;
  logic        rd_req_q, rd_req_d;
  logic        wr_req_q, wr_req_d;
  logic [9:0]  tmo_q, tmo_d;
  logic        rrdy_prev_q, rrdy_prev_d;
  logic        seen_busy_q, seen_busy_d;
  logic [31:0] f_data_q, f_data_d;
  logic        f_ready_q, f_ready_d;
  logic [15:0] d_rdata_q, d_rdata_d;
  logic        d_ready_q, d_ready_d;
  logic        timeout_q, timeout_d;

`ifdef ARB_RR_EN
  logic        data_last_q, data_last_d;
`else
  localparam int SW = $clog2(MAX_DATA_STREAK + 1);
  logic [SW-1:0] streak_q, streak_d;
`endif

  logic        d_pend;
  logic        can_grant;
  logic        fetch_first;
  logic        grant_f;
  logic        grant_d;
  logic [9:0]  tmo_inc;
  logic        tmo_hit;

  always_comb begin
    d_pend    = bus.d_rd_req | bus.d_wr_req;
    can_grant = (state_q == S_IDLE) && !bus.m_busy && !(f_ready_q | d_ready_q | timeout_q);
`ifdef ARB_RR_EN
    fetch_first = bus.f_req && (!d_pend || data_last_q);
`else
    fetch_first = bus.f_req && (!d_pend || (streak_q == SW'(MAX_DATA_STREAK)));
`endif
    grant_f = can_grant && fetch_first;
    grant_d = can_grant && d_pend && !fetch_first;
    tmo_inc = tmo_q + 10'd1;
    tmo_hit = (tmo_inc == TMO_LIMIT);
  end

`ifdef ARB_RR_EN
  always_comb begin
    data_last_d = data_last_q;
    if (grant_d) begin
      data_last_d = 1'b1;
    end else if (grant_f) begin
      data_last_d = 1'b0;
    end
  end
`else
  // streak only counts data grants that actually made a fetch wait
  always_comb begin
    streak_d = streak_q;
    if (grant_d && bus.f_req) begin
      if (streak_q != SW'(MAX_DATA_STREAK)) begin
        streak_d = streak_q + SW'(1);
      end
    end else if (grant_f || ((state_q == S_IDLE) && !bus.f_req)) begin
      streak_d = '0;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    instr_d     = instr_q;
    rd_req_d    = rd_req_q;
    wr_req_d    = wr_req_q;
    tmo_d       = tmo_q;
    rrdy_prev_d = rrdy_prev_q;
    seen_busy_d = seen_busy_q;
    f_data_d    = f_data_q;
    d_rdata_d   = d_rdata_q;
    f_ready_d   = 1'b0;
    d_ready_d   = 1'b0;
    timeout_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (grant_f) begin
          state_d     = S_ISSUE;
          kind_d      = K_FETCH;
          addr_d      = bus.f_addr;
          instr_d     = 1'b1;
          rd_req_d    = 1'b1;
          tmo_d       = '0;
          rrdy_prev_d = 1'b0;
          seen_busy_d = 1'b0;
        end else if (grant_d) begin
          state_d     = S_ISSUE;
          kind_d      = bus.d_wr_req ? K_DWR : K_DRD;
          addr_d      = bus.d_addr;
          wdata_d     = bus.d_wdata;
          instr_d     = 1'b0;
          rd_req_d    = !bus.d_wr_req;
          wr_req_d    = bus.d_wr_req;
          tmo_d       = '0;
          rrdy_prev_d = 1'b0;
          seen_busy_d = 1'b0;
        end
      end

      S_ISSUE: begin
        tmo_d       = tmo_inc;
        rrdy_prev_d = bus.m_read_ready;
        if (tmo_hit) begin
          state_d   = S_IDLE;
          rd_req_d  = 1'b0;
          wr_req_d  = 1'b0;
          instr_d   = 1'b0;
          timeout_d = 1'b1;
        end else if (bus.m_cack) begin
          rd_req_d = 1'b0;
          wr_req_d = 1'b0;
          state_d  = (kind_q == K_DWR) ? S_WAIT_WR : S_WAIT_RD;
        end
      end

      S_WAIT_RD: begin
        tmo_d       = tmo_inc;
        rrdy_prev_d = bus.m_read_ready;
        if (bus.m_read_ready && !rrdy_prev_q) begin
          state_d = S_IDLE;
          instr_d = 1'b0;
          if (kind_q == K_FETCH) begin
            f_data_d  = bus.m_rdata;
            f_ready_d = 1'b1;
          end else begin
            d_rdata_d = bus.m_rdata[15:0];
            d_ready_d = 1'b1;
          end
        end else if (tmo_hit) begin
          state_d   = S_IDLE;
          instr_d   = 1'b0;
          timeout_d = 1'b1;
        end
      end

      S_WAIT_WR: begin
        tmo_d = tmo_inc;
        if (bus.m_busy) begin
          seen_busy_d = 1'b1;
        end
        if (seen_busy_q && !bus.m_busy) begin
          state_d   = S_IDLE;
          d_ready_d = 1'b1;
        end else if (tmo_hit) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
        end
      end

      default: begin
        state_d  = S_IDLE;
        rd_req_d = 1'b0;
        wr_req_d = 1'b0;
        instr_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      kind_q      <= K_FETCH;
      addr_q      <= '0;
      wdata_q     <= '0;
      instr_q     <= 1'b0;
      rd_req_q    <= 1'b0;
      wr_req_q    <= 1'b0;
      tmo_q       <= '0;
      rrdy_prev_q <= 1'b0;
      seen_busy_q <= 1'b0;
      f_data_q    <= '0;
      f_ready_q   <= 1'b0;
      d_rdata_q   <= '0;
      d_ready_q   <= 1'b0;
      timeout_q   <= 1'b0;
`ifdef ARB_RR_EN
      data_last_q <= 1'b0;
`else
      streak_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      instr_q     <= instr_d;
      rd_req_q    <= rd_req_d;
      wr_req_q    <= wr_req_d;
      tmo_q       <= tmo_d;
      rrdy_prev_q <= rrdy_prev_d;
      seen_busy_q <= seen_busy_d;
      f_data_q    <= f_data_d;
      f_ready_q   <= f_ready_d;
      d_rdata_q   <= d_rdata_d;
      d_ready_q   <= d_ready_d;
      timeout_q   <= timeout_d;
`ifdef ARB_RR_EN
      data_last_q <= data_last_d;
`else
      streak_q    <= streak_d;
`endif
    end
  end

  assign bus.f_data       = f_data_q;
  assign bus.f_ready      = f_ready_q;
  assign bus.d_rdata      = d_rdata_q;
  assign bus.d_ready      = d_ready_q;
  assign bus.m_addr       = addr_q;
  assign bus.m_wdata      = wdata_q;
  assign bus.m_read_req   = rd_req_q;
  assign bus.m_write_req  = wr_req_q;
  assign bus.m_instr_mode = instr_q;
  assign bus.arb_timeout  = timeout_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: the initial block plays requesters and SDRAM controller.
module tb_sdram_port_arbiter;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   f_cnt;
  int   d_cnt;
  logic [15:0] mem_word;

  sdram_port_arbiter_if bus ();

  sdram_port_arbiter #(
    .MAX_DATA_STREAK (4),
    .TIMEOUT_CYC     (1023)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.f_ready) f_cnt <= f_cnt + 1;
    if (bus.d_ready) d_cnt <= d_cnt + 1;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_req();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.m_read_req || bus.m_write_req) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("req_seen", 32'(ok), 32'd1);
  endtask

  // controller side of a read; returns at the negedge where the ready pulse is visible
  task automatic ctl_read(input logic [31:0] data_v);
    wait_req();
    @(negedge clk);
    chk("rd_req_held", 32'(bus.m_read_req), 32'd1);
    bus.m_cack = 1'b1;
    @(negedge clk);
    bus.m_cack = 1'b0;
    chk("rd_req_drop", 32'(bus.m_read_req), 32'd0);
    @(negedge clk);
    bus.m_rdata      = data_v;
    bus.m_read_ready = 1'b1;
    @(negedge clk);
    bus.m_read_ready = 1'b0;
  endtask

  task automatic ctl_write();
    wait_req();
    mem_word   = bus.m_wdata;
    bus.m_cack = 1'b1;
    @(negedge clk);
    bus.m_cack = 1'b0;
    bus.m_busy = 1'b1;
    chk("wr_req_drop", 32'(bus.m_write_req), 32'd0);
    @(negedge clk);
    chk("wr_no_early_ready", 32'(bus.d_ready), 32'd0);
    @(negedge clk);
    bus.m_busy = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int f0, d0;
    errors = 0;
    checks = 0;
    f_cnt  = 0;
    d_cnt  = 0;
    mem_word = '0;
    rst_n = 1'b0;
    bus.f_addr = '0;  bus.f_req = 1'b0;
    bus.d_addr = '0;  bus.d_wdata = '0;  bus.d_rd_req = 1'b0;  bus.d_wr_req = 1'b0;
    bus.m_rdata = '0; bus.m_busy = 1'b0; bus.m_read_ready = 1'b0; bus.m_cack = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_f_ready", 32'(bus.f_ready), 32'd0);
    chk("rst_d_ready", 32'(bus.d_ready), 32'd0);
    chk("rst_m_read_req", 32'(bus.m_read_req), 32'd0);
    chk("rst_m_write_req", 32'(bus.m_write_req), 32'd0);
    chk("rst_instr", 32'(bus.m_instr_mode), 32'd0);
    chk("rst_m_addr", 32'(bus.m_addr), 32'd0);
    chk("rst_timeout", 32'(bus.arb_timeout), 32'd0);
    chk("rst_f_data", bus.f_data, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // single fetch
    f0 = f_cnt; d0 = d_cnt;
    bus.f_addr = 23'h000100;
    bus.f_req  = 1'b1;
    wait_req();
    chk("fetch_instr", 32'(bus.m_instr_mode), 32'd1);
    chk("fetch_addr", 32'(bus.m_addr), 32'h000100);
    chk("fetch_no_wr", 32'(bus.m_write_req), 32'd0);
    ctl_read(32'hDEADBEEF);
    chk("fetch_ready", 32'(bus.f_ready), 32'd1);
    chk("fetch_data", bus.f_data, 32'hDEADBEEF);
    chk("fetch_no_dready", 32'(bus.d_ready), 32'd0);
    bus.f_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("fetch_ready_count", 32'(f_cnt - f0), 32'd1);
    chk("fetch_dready_count", 32'(d_cnt - d0), 32'd0);
    chk("fetch_no_reissue", 32'(bus.m_read_req), 32'd0);

    // data write then read back
    d0 = d_cnt;
    bus.d_addr   = 23'h000010;
    bus.d_wdata  = 16'h1234;
    bus.d_wr_req = 1'b1;
    wait_req();
    chk("wr_req", 32'(bus.m_write_req), 32'd1);
    chk("wr_no_rd", 32'(bus.m_read_req), 32'd0);
    chk("wr_addr", 32'(bus.m_addr), 32'h000010);
    chk("wr_wdata", 32'(bus.m_wdata), 32'h1234);
    chk("wr_instr", 32'(bus.m_instr_mode), 32'd0);
    ctl_write();
    chk("wr_ready", 32'(bus.d_ready), 32'd1);
    bus.d_wr_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("wr_ready_count", 32'(d_cnt - d0), 32'd1);
    bus.d_rd_req = 1'b1;
    wait_req();
    chk("rd_addr", 32'(bus.m_addr), 32'h000010);
    ctl_read({16'hFFFF, mem_word});
    chk("rd_ready", 32'(bus.d_ready), 32'd1);
    chk("rd_data", 32'(bus.d_rdata), 32'h1234);
    chk("f_data_held", bus.f_data, 32'hDEADBEEF);
    bus.d_rd_req = 1'b0;
    repeat (2) @(negedge clk);

    // simultaneous read and write: write wins
    bus.d_addr   = 23'h000020;
    bus.d_wdata  = 16'h5A5A;
    bus.d_rd_req = 1'b1;
    bus.d_wr_req = 1'b1;
    wait_req();
    chk("both_write_first", 32'(bus.m_write_req), 32'd1);
    ctl_write();
    chk("both_wr_ready", 32'(bus.d_ready), 32'd1);
    bus.d_wr_req = 1'b0;
    wait_req();
    chk("both_read_second", 32'(bus.m_read_req), 32'd1);
    ctl_read({16'hFFFF, mem_word});
    chk("both_rd_data", 32'(bus.d_rdata), 32'h5A5A);
    bus.d_rd_req = 1'b0;
    repeat (2) @(negedge clk);

    // starvation bound: 4 data grants then 1 fetch, repeating
    bus.f_addr   = 23'h000200;
    bus.d_addr   = 23'h000030;
    bus.f_req    = 1'b1;
    bus.d_rd_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      logic is_f;
      is_f = ((i % 5) == 4);
      wait_req();
      chk($sformatf("streak_instr_%0d", i), 32'(bus.m_instr_mode), 32'(is_f));
      ctl_read(32'hA0000000 + 32'(i));
      chk($sformatf("streak_f_ready_%0d", i), 32'(bus.f_ready), 32'(is_f));
      chk($sformatf("streak_d_ready_%0d", i), 32'(bus.d_ready), 32'(!is_f));
    end
    chk("streak_f_data", bus.f_data, 32'hA0000009);
    chk("streak_d_data", 32'(bus.d_rdata), 32'h0008);
    bus.f_req    = 1'b0;
    bus.d_rd_req = 1'b0;
    repeat (2) @(negedge clk);

    // timeout: controller never acknowledges
    d0 = d_cnt;
    bus.d_addr   = 23'h000040;
    bus.d_rd_req = 1'b1;
    wait_req();
    repeat (1022) @(negedge clk);
    chk("tmo_not_yet", 32'(bus.arb_timeout), 32'd0);
    chk("tmo_req_still", 32'(bus.m_read_req), 32'd1);
    @(negedge clk);
    chk("tmo_pulse", 32'(bus.arb_timeout), 32'd1);
    chk("tmo_req_drop", 32'(bus.m_read_req), 32'd0);
    chk("tmo_no_ready", 32'(bus.d_ready), 32'd0);
    @(negedge clk);
    chk("tmo_pulse_end", 32'(bus.arb_timeout), 32'd0);
    chk("tmo_idle_gap", 32'(bus.m_read_req), 32'd0);
    @(negedge clk);
    chk("tmo_reissue", 32'(bus.m_read_req), 32'd1);
    ctl_read(32'h0000BEEF);
    chk("tmo_retry_data", 32'(bus.d_rdata), 32'hBEEF);
    bus.d_rd_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("tmo_ready_count", 32'(d_cnt - d0), 32'd1);

    // async reset in WAIT_RD, late read_ready discarded
    bus.f_addr = 23'h000300;
    bus.f_req  = 1'b1;
    wait_req();
    bus.m_cack = 1'b1;
    @(negedge clk);
    bus.m_cack = 1'b0;
    f0 = f_cnt; d0 = d_cnt;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_instr", 32'(bus.m_instr_mode), 32'd0);
    chk("arst_addr", 32'(bus.m_addr), 32'd0);
    chk("arst_f_data", bus.f_data, 32'd0);
    chk("arst_d_rdata", 32'(bus.d_rdata), 32'd0);
    bus.f_req = 1'b0;
    @(negedge clk);
    bus.m_rdata      = 32'h12345678;
    bus.m_read_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    bus.m_read_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("arst_no_f_ready", 32'(f_cnt - f0), 32'd0);
    chk("arst_no_d_ready", 32'(d_cnt - d0), 32'd0);
    chk("arst_f_data_after", bus.f_data, 32'd0);
    chk("arst_no_req", 32'(bus.m_read_req), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
